// File: rtl/kernel_load_ctrl_pkg.sv
// Shared types and constants for the kernel load controller.
// Holds the FSM state encoding and the ping-pong bank count.
package kernel_load_ctrl_pkg;

    localparam int BANKS = 2;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_LOAD = 1'b1;

endpackage

// File: rtl/kernel_bank_tracker.sv
// Ping-pong bank bookkeeping: which bank is being written, which is read,
// and which banks currently hold a complete kernel.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_done   : a load into wr_bank terminated this cycle
//   k_release   : datapath releases rd_bank (ignored when k_valid=0)
//   wr_bank     : bank the loader writes next
//   rd_bank     : bank the datapath reads
//   bank_valid  : per-bank complete-kernel flags
//   k_valid     : bank_valid[rd_bank]
module kernel_bank_tracker
    import kernel_load_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_done,
    input  logic             k_release,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic [BANKS-1:0] bank_valid,
    output logic             k_valid
);

    logic             release_ok;
    logic [BANKS-1:0] bank_valid_nxt;

    assign k_valid    = bank_valid[rd_bank];
    assign release_ok = k_release & k_valid;

    // A load into wr_bank and a release of rd_bank can coincide; they
    // never target the same bank because a bank is only loaded while empty.
    always_comb begin
        bank_valid_nxt = bank_valid;
        if (load_done) begin
            bank_valid_nxt[wr_bank] = 1'b1;
        end
        if (release_ok) begin
            bank_valid_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_valid <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
        end else begin
            bank_valid <= bank_valid_nxt;
            if (load_done) begin
                wr_bank <= ~wr_bank;
            end
            if (release_ok) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: rtl/kernel_load_ctrl.sv
// Loads kernel/bias beats from a stream into two ping-pong kernel_buffer
// banks and hands complete banks to the datapath.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input kernel stream
//   buff_data  : broadcast write data (= s_data)
//   buff_en    : one-hot word strobe, bit b*N_WORDS+i = bank b word i
//   k_valid    : rd_bank holds a complete kernel
//   rd_bank    : bank the datapath reads
//   k_release  : datapath done with rd_bank
//   err_len    : sticky, a load ended with s_last misplaced
module kernel_load_ctrl
    import kernel_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int UNITS      = 10,
    parameter int N_WORDS    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH*UNITS-1:0] s_data,
    input  logic                        s_last,
    output logic [DATA_WIDTH*UNITS-1:0] buff_data,
    output logic [2*N_WORDS-1:0]        buff_en,
    output logic                        k_valid,
    output logic                        rd_bank,
    input  logic                        k_release,
    output logic                        err_len
);

    localparam int CW = $clog2(N_WORDS);

    state_t           state;
    logic [CW-1:0]    word_cnt;
    logic             wr_bank;
    logic [BANKS-1:0] bank_valid;
    logic             hs;
    logic             last_word;
    logic             load_done;

    assign s_ready   = (state == ST_LOAD);
    assign hs        = s_valid & s_ready;
    assign last_word = (word_cnt == CW'(N_WORDS - 1));
    // Whichever comes first ends the load: s_last or a full bank.
    assign load_done = hs & (s_last | last_word);
    assign buff_data = s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bank_valid[wr_bank]) begin
                        state    <= ST_LOAD;
                        word_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_done) begin
                        state <= ST_IDLE;
                    end else if (hs) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Early s_last and missing s_last both flag a length error.
            if (load_done && (s_last != last_word)) begin
                err_len <= 1'b1;
            end
        end
    end

    always_comb begin
        buff_en = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < N_WORDS; i++) begin
                buff_en[b*N_WORDS+i] = hs
                    && (wr_bank == 1'(b))
                    && (word_cnt == CW'(i));
            end
        end
    end

    kernel_bank_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .load_done  (load_done),
        .k_release  (k_release),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .bank_valid (bank_valid),
        .k_valid    (k_valid)
    );

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Self-checking bench for kernel_load_ctrl.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_kernel_load_ctrl;

    localparam int DW = 16;
    localparam int U  = 10;
    localparam int N  = 10;
    localparam int W  = DW * U;
    localparam int NE = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic [W-1:0]  buff_data;
    logic [NE-1:0] buff_en;
    logic          k_valid;
    logic          rd_bank;
    logic          k_release;
    logic          err_len;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;
    int slog[$];

    // Model: loader is either streaming into m_wr or waiting; complete
    // kernels sit in a FIFO of at most two entries, head is read next.
    bit   m_loading;
    int   m_cnt;
    bit   m_wr;
    bit   m_rd;
    bit   m_err;
    bit   full_q[$];

    always #5 clk = ~clk;

    kernel_load_ctrl #(
        .DATA_WIDTH (DW),
        .UNITS      (U),
        .N_WORDS    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .buff_data (buff_data),
        .buff_en   (buff_en),
        .k_valid   (k_valid),
        .rd_bank   (rd_bank),
        .k_release (k_release),
        .err_len   (err_len)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit hs;
        bit was_loading;
        int occ;
        if (rst) begin
            m_loading = 0;
            m_cnt     = 0;
            m_wr      = 0;
            m_rd      = 0;
            m_err     = 0;
            full_q.delete();
        end else begin
            hs          = s_valid && m_loading;
            was_loading = m_loading;
            occ         = full_q.size();
            if (k_release && occ > 0) begin
                void'(full_q.pop_front());
                m_rd = ~m_rd;
            end
            if (hs) begin
                if (s_last || m_cnt == N - 1) begin
                    if (s_last != (m_cnt == N - 1)) m_err = 1;
                    full_q.push_back(m_wr);
                    m_wr      = ~m_wr;
                    m_loading = 0;
                    m_cnt     = 0;
                end else begin
                    m_cnt++;
                end
            end
            // The loader needs a free bank, judged on pre-edge occupancy.
            if (!was_loading && occ < 2) begin
                m_loading = 1;
                m_cnt     = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NE; k++) begin
            if (buff_en[k] === 1'b1) slog.push_back(k);
        end
        if (cmp_en) begin
            logic [NE-1:0] e_en;
            e_en = '0;
            if (s_valid && m_loading) e_en[int'(m_wr)*N + m_cnt] = 1'b1;
            chk("s_ready", W'(s_ready), W'(m_loading));
            chk("buff_en", W'(buff_en), W'(e_en));
            chk("k_valid", W'(k_valid), W'(full_q.size() > 0));
            chk("rd_bank", W'(rd_bank), W'(m_rd));
            chk("err_len", W'(err_len), W'(m_err));
            chk("buff_data", buff_data, s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < W / 32; k++) s_data[k*32 +: 32] = $urandom;
    endtask

    // Present nb beats; s_last on beat last_at (0 = never); k_release
    // raised together with beat rel_at (0 = never).
    task automatic send(input int nb, input int last_at, input int rel_at);
        int  i;
        int  cyc;
        bit  acc;
        i   = 1;
        cyc = 0;
        s_valid   = 1;
        rand_data();
        s_last    = (i == last_at);
        k_release = (i == rel_at);
        while (i <= nb) begin
            acc = s_ready;
            tick();
            cyc++;
            k_release = 0;
            if (acc) begin
                i++;
                rand_data();
                s_last    = (i == last_at);
                k_release = (i == rel_at) && (i <= nb);
            end
            if (cyc > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout beats=%0d required=%0d", i - 1, nb);
                break;
            end
        end
        s_valid   = 0;
        s_last    = 0;
        k_release = 0;
    endtask

    task automatic chk_log(input string nm, input int base, input int n);
        chk({nm, "_len"}, W'(slog.size()), W'(n));
        for (int k = 0; k < n && k < slog.size(); k++) begin
            chk(nm, W'(slog[k]), W'(base + k));
        end
        slog.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic pulse_release();
        k_release = 1;
        tick();
        k_release = 0;
    endtask

    initial begin
        rst       = 1;
        s_valid   = 0;
        s_last    = 0;
        s_data    = '0;
        k_release = 0;
        tick();
        cmp_en = 1;
        tick();
        rst = 0;

        // Reset values and first ready two cycles after reset release.
        chk("rst_ready", W'(s_ready), W'(0));
        chk("rst_kvalid", W'(k_valid), W'(0));
        chk("rst_en", W'(buff_en), W'(0));
        chk("rst_rd", W'(rd_bank), W'(0));
        chk("rst_err", W'(err_len), W'(0));
        tick();
        chk("first_ready", W'(s_ready), W'(1));

        // One full kernel into bank 0.
        slog.delete();
        send(10, 10, 0);
        chk_log("walk0", 0, 10);
        chk("k1_kvalid", W'(k_valid), W'(1));
        chk("k1_rd", W'(rd_bank), W'(0));
        chk("k1_err", W'(err_len), W'(0));

        // Second kernel fills bank 1; third must stall.
        send(10, 10, 0);
        chk_log("walk1", 10, 10);
        s_valid = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("full_stall", W'(s_ready), W'(0));
        end
        s_valid = 0;
        slog.delete();
        pulse_release();
        chk("rel_rd", W'(rd_bank), W'(1));
        chk("rel_ready0", W'(s_ready), W'(0));
        tick();
        chk("rel_ready1", W'(s_ready), W'(1));
        send(10, 10, 0);
        chk_log("walk2", 0, 10);

        // Early s_last on beat 4.
        do_reset();
        tick();
        slog.delete();
        send(4, 4, 0);
        chk_log("early", 0, 4);
        chk("early_err", W'(err_len), W'(1));
        chk("early_kvalid", W'(k_valid), W'(1));
        send(10, 10, 0);
        chk_log("early_next", 10, 10);

        // Missing s_last.
        do_reset();
        tick();
        send(10, 0, 0);
        chk("nolast_err", W'(err_len), W'(1));
        chk("nolast_kvalid", W'(k_valid), W'(1));

        // Release coinciding with bank 1's final beat.
        do_reset();
        tick();
        send(10, 10, 0);
        send(10, 10, 10);
        chk("coinc_rd", W'(rd_bank), W'(1));
        chk("coinc_kvalid", W'(k_valid), W'(1));
        chk("coinc_err", W'(err_len), W'(0));

        // Reset mid-load.
        do_reset();
        tick();
        send(5, 0, 0);
        rst     = 1;
        s_valid = 1;
        tick();
        chk("mid_ready", W'(s_ready), W'(0));
        chk("mid_kvalid", W'(k_valid), W'(0));
        chk("mid_en", W'(buff_en), W'(0));
        rst     = 0;
        s_valid = 0;
        tick();
        slog.delete();
        send(10, 10, 0);
        chk_log("mid_walk", 0, 10);

        // Randomized traffic checked every cycle by the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_valid   = ($urandom_range(0, 9) < 7);
            s_last    = ($urandom_range(0, 7) == 0);
            k_release = ($urandom_range(0, 4) == 0);
            rand_data();
            tick();
        end
        s_valid   = 0;
        s_last    = 0;
        k_release = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kernel_load_ctrl.md
# kernel_load_ctrl

Sequences the loading of kernel and bias words from an input stream into two ping-pong banks of `kernel_buffer` registers. It generates the one-hot `buff_en` strobes and a broadcast data bus for those banks. It tracks which bank holds a complete kernel and hands banks to the convolution datapath through a valid/release handshake. The block sits between the kernel DMA stream and the `kernel_buffer` instances that feed the processing units.

## Interface
- `DATA_WIDTH`, 16: bits per unit word (matches `kernel_buffer`).
- `UNITS`, 10: parallel units per stream beat (matches `kernel_buffer`).
- `N_WORDS`, 10: beats per kernel load (taps + 1 bias); ≥2.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `s_valid` input 1: stream beat valid.
- `s_ready` output 1: stream beat accepted when `s_valid & s_ready`.
- `s_data` input DATA_WIDTH*UNITS: kernel/bias beat.
- `s_last` input 1: marks final beat of a kernel.
- `buff_data` output DATA_WIDTH*UNITS: broadcast to every `kernel_buffer.x_in`; equals `s_data` (combinational).
- `buff_en` output 2*N_WORDS: one-hot write strobe. Bit `b*N_WORDS+i` drives word i of bank b.
- `k_valid` output 1: bank `rd_bank` holds a complete kernel.
- `rd_bank` output 1: bank the datapath must read.
- `k_release` input 1: single-cycle pulse; datapath is finished with `rd_bank`.
- `err_len` output 1: sticky; a load ended with `s_last` misplaced.

## Operation
- Bank state is held in `bank_valid[1:0]`, `wr_bank`, and `rd_bank`. After reset, all of these are 0.
- FSM states are IDLE and LOAD.
  - IDLE → LOAD when `bank_valid[wr_bank]==0`.
  - LOAD → IDLE on a load-terminating handshake.
- `s_ready = (state==LOAD)`. Otherwise `s_ready` is 0.
- `word_cnt` counts 0..N_WORDS-1. It clears on entry to LOAD.
- On each accepted beat in LOAD:
  - `buff_en[wr_bank*N_WORDS+word_cnt]=1` combinationally in that cycle. All other `buff_en` bits are 0.
  - `word_cnt` increments.
- The load terminates on the first of two events: `word_cnt==N_WORDS-1` or `s_last=1`.
- On a terminating handshake:
  - `bank_valid[wr_bank]<=1` and `wr_bank` toggles.
  - `err_len<=1` if `s_last` does not coincide with `word_cnt==N_WORDS-1`. This covers both an early `s_last` and a missing `s_last`.
  - After an early `s_last`, the remaining words of that bank keep their previous contents.
- `k_valid = bank_valid[rd_bank]`.
- When `k_release` arrives with `k_valid=1`:
  - `bank_valid[rd_bank]<=0` and `rd_bank` toggles.
  - A `k_release` with `k_valid=0` is ignored.
- Release of `rd_bank` and load completion into the other bank may occur in the same cycle. Both updates take effect.
- The block does not reset the `kernel_buffer` contents; those have their own reset.
- The IDLE → LOAD check uses the registered `bank_valid`. A bank released in cycle t is refilled starting at t+2 (one cycle in IDLE).

## Timing
- Output values after `rst`:
  - `s_ready`=0, `buff_en`=0, `k_valid`=0, `rd_bank`=0, `err_len`=0.
  - `buff_data` follows `s_data` and has no reset value.
- First `s_ready` is asserted 2 cycles after `rst` deasserts: one cycle in IDLE, then LOAD.
- Write latency: a beat accepted at edge t appears at the `kernel_buffer` output after edge t.
- `k_valid` rises after the same edge that captures the final word. Data and valid are therefore coherent.
- Back-to-back beats are accepted every cycle within a load. The gap between loads is 1 cycle (IDLE).
- When both banks are valid, `s_ready` stays 0 until a release. There is no overflow.
- `rst` asserted mid-load aborts the load:
  - `word_cnt`, `bank_valid`, both bank pointers, and `err_len` clear.
  - Words already written remain in the buffers but are not flagged valid.
- `err_len` clears only on `rst`.

## Structure
- Shared package holds the FSM state enum (IDLE, LOAD) and a `BANKS=2` constant.
- `$clog2(N_WORDS)` is computed locally.
- One natural sub-module: `kernel_bank_tracker`. It holds `bank_valid`, `wr_bank`, `rd_bank`, and the release logic.
- The top level is the FSM, counter, and strobe decode. It instantiates 2*N_WORDS `kernel_buffer` only in the integration wrapper, not in this block.

## Test plan
- Reset, then stream 10 beats with `s_last` on beat 10 (N_WORDS=10) → `buff_en` walks bits 0..9 once each; `k_valid=1` one edge after beat 10; `rd_bank=0`; `err_len=0`.
- Stream 30 beats as three kernels with no releases → banks 0 and 1 fill; `s_ready` drops after beat 20 and stays low. Pulse `k_release` → `rd_bank=1`; `s_ready` returns 2 cycles later; beats 21..30 strobe bits 0..9.
- `s_last` on beat 4 → bits 0..3 strobed; bank 0 valid; `err_len=1`; the next load targets bank 1 (bits 10..19).
- Beat 10 without `s_last` → load still terminates after 10 beats; `err_len=1`.
- `k_release` in the same cycle as bank 1's final beat → `bank_valid` becomes {1,0}; `rd_bank=1`; `k_valid` stays 1.
- `rst` asserted after 5 beats → `s_ready`, `k_valid`, and `buff_en` are 0 next cycle. A fresh 10-beat load then targets bank 0 from bit 0.
